ysyx_22040895_ifu: RTL and testbench
====================================

// Module: ysyx_22040895_ifu
// PURPOSE
//  Instruction fetch responder: accepts the fetch address and chip-enable driven by the PC stage and returns
//  the 32-bit instruction at that address to decode. Reads 64-bit doublewords over a valid/ready read bus.
//  Keeps a one-entry doubleword buffer so the sequential pc, pc+4 pair costs one bus read. Drops in-flight
//  fetches on a branch redirect.
// PARAMETERS
//  ADDR_W     64   fetch/bus address width
//  TIMEOUT    255  cycles waiting for r_valid before raising access fault (8-bit counter, max 255)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-low reset
//  ce_i_ifu     in   1       fetch enable from PC stage
//  pc_i_ifu     in   ADDR_W  fetch address, 4-byte aligned
//  flush_i_ifu  in   1       branch redirect; discard current fetch
//  ar_valid_o   out  1       read request valid
//  ar_ready_i   in   1       bus accepts request
//  ar_addr_o    out  ADDR_W  doubleword-aligned request address {pc[ADDR_W-1:3],3'b0}
//  r_valid_i    in   1       read data valid
//  r_ready_o    out  1       IFU accepts read data
//  r_data_i     in   64      read doubleword
//  r_resp_i     in   2       00 OKAY, other = error
//  inst_o       out  32      instruction to decode
//  inst_pc_o    out  ADDR_W  address of inst_o
//  inst_valid_o out  1       inst_o/inst_pc_o valid
//  inst_ready_i in   1       decode consumes instruction
//  fault_o      out  1       access fault tag on current inst (bus error or timeout)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, ar_valid_o=0, r_ready_o=0, inst_valid_o=0, fault_o=0, inst_o=0,
//   inst_pc_o=0, ar_addr_o=0, buffer valid bit=0, timeout counter=0. Reset mid-transaction abandons it.
//  States: IDLE, REQ, WAIT, OUT, DRAIN.
//  IDLE: when ce_i_ifu=1 and flush_i_ifu=0, latch pc_i_ifu. If buffer valid and tag==pc[ADDR_W-1:3] -> OUT
//   next cycle (hit, 1-cycle latency); else -> REQ, ar_valid_o=1 with ar_addr_o from latched pc.
//  REQ: hold ar_valid_o and ar_addr_o stable until ar_ready_i=1 (handshake in same cycle) -> WAIT.
//   Flush in REQ with ar_ready_i=0: drop request, -> IDLE; with ar_ready_i=1: -> DRAIN.
//  WAIT: r_ready_o=1. On r_valid_i: if r_resp_i==00 write buffer {tag,data}, valid=1, fault_o=0;
//   else buffer valid=0, fault_o=1. -> OUT. Counter increments each WAIT cycle; at TIMEOUT -> OUT
//   with fault_o=1, inst_o=0 (and -> DRAIN on the next flush/consume so the late beat is discarded).
//   Flush in WAIT -> DRAIN (response still owed by bus).
//  DRAIN: r_ready_o=1, discard beat, do not update buffer, -> IDLE on r_valid_i. Flush in DRAIN ignored.
//  OUT: inst_valid_o=1; inst_o = pc[2] ? data[63:32] : data[31:0]; inst_pc_o = latched pc. Outputs held
//   stable until inst_ready_i=1, then -> IDLE (inst_valid_o=0 next cycle). Flush in OUT: inst_valid_o
//   deasserts next cycle, -> IDLE; flush overrides inst_ready_i in the same cycle.
//  Miss latency: ar handshake + read latency + 1 cycle to inst_valid_o. No new request while not IDLE;
//   at most one outstanding read.
//  Buffer invalidated on reset only; error responses never fill it.
//  pc_i_ifu[1:0]!=0 is not checked; low two bits are ignored.
// TESTING
//  Miss: pc=0x80000000, ar_ready=1, r_data=0x0000_0013_0000_0093 one cycle later -> ar_addr=0x80000000,
//   inst_o=0x00000093, inst_pc_o=0x80000000.
//  Hit: next pc=0x80000004 -> no ar_valid, inst_o=0x00000013 one cycle after IDLE accept.
//  Backpressure: ar_ready low 3 cycles, then inst_ready low 2 cycles -> ar_addr and inst_o stable throughout.
//  Flush in WAIT, then new pc=0x80000100 -> stale beat drained, buffer unchanged, next ar_addr=0x80000100.
//  Error: r_resp=2'b10 -> fault_o=1 with inst_valid_o=1; refetch same pc issues new ar (no buffer hit).
//  Timeout: no r_valid for 255 cycles -> fault_o=1, inst_valid_o=1; async rst=0 mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit for ysyx_22040895.
// Returns the 32-bit instruction at the PC-stage address.
// Doublewords are read over a valid/ready bus.
// A one-entry doubleword buffer lets a sequential pc/pc+4 pair share one bus read.
// A branch redirect drops the in-flight fetch; any response still owed by the bus is drained.
module ysyx_22040895_ifu #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i_ifu,
  input  logic [ADDR_W-1:0] pc_i_ifu,
  input  logic              flush_i_ifu,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [ADDR_W-1:0] ar_addr_o,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [63:0]       r_data_i,
  input  logic [1:0]        r_resp_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              fault_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_t;

  // r_cnt reaching this value closes the last WAIT cycle, giving TIMEOUT cycles in total.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-4:0]   r_bufTag;
  logic [63:0]         r_bufData;
  logic                r_bufValid;
  logic [7:0]          r_cnt;
  logic                r_fault;
  logic                r_timedOut;
  logic [31:0]         r_inst;

  logic                w_accept;
  logic                w_hit;
  logic                w_timeout;
  logic                w_okay;

  assign w_accept  = ce_i_ifu && !flush_i_ifu;
  assign w_hit     = r_bufValid && (r_bufTag == pc_i_ifu[ADDR_W-1:3]);
  assign w_timeout = (r_cnt == TIMEOUT_LAST);
  assign w_okay    = (r_resp_i == 2'b00);

  assign ar_valid_o   = (r_state == S_REQ);
  assign ar_addr_o    = {r_pc[ADDR_W-1:3], 3'b000};
  assign r_ready_o    = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign inst_valid_o = (r_state == S_OUT);
  assign fault_o      = (r_state == S_OUT) && r_fault;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_pc;

  // State register; reset abandons any transaction in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic. A beat that arrives together with a flush is consumed and dropped.
  // After a timeout the late beat is still owed by the bus, so leaving OUT goes through DRAIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_hit ? S_OUT : S_REQ;
      end
      S_REQ: begin
        if (flush_i_ifu)     w_next = ar_ready_i ? S_DRAIN : S_IDLE;
        else if (ar_ready_i) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_valid_i)        w_next = flush_i_ifu ? S_IDLE : S_OUT;
        else if (flush_i_ifu) w_next = S_DRAIN;
        else if (w_timeout)   w_next = S_OUT;
      end
      S_OUT: begin
        if (flush_i_ifu || inst_ready_i) w_next = r_timedOut ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (r_valid_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latches the fetch pc, runs the timeout counter,
  // and fills the buffer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= '0;
      r_bufTag   <= '0;
      r_bufData  <= '0;
      r_bufValid <= 1'b0;
      r_cnt      <= '0;
      r_fault    <= 1'b0;
      r_timedOut <= 1'b0;
      r_inst     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc       <= pc_i_ifu;
            r_cnt      <= '0;
            r_fault    <= 1'b0;
            r_timedOut <= 1'b0;
            if (w_hit) r_inst <= pc_i_ifu[2] ? r_bufData[63:32] : r_bufData[31:0];
          end
        end
        S_WAIT: begin
          if (r_valid_i) begin
            if (!flush_i_ifu) begin
              if (w_okay) begin
                r_bufTag   <= r_pc[ADDR_W-1:3];
                r_bufData  <= r_data_i;
                r_bufValid <= 1'b1;
                r_fault    <= 1'b0;
                r_inst     <= r_pc[2] ? r_data_i[63:32] : r_data_i[31:0];
              end else begin
                r_bufValid <= 1'b0;
                r_fault    <= 1'b1;
                r_inst     <= '0;
              end
            end
          end else if (!flush_i_ifu) begin
            if (w_timeout) begin
              r_fault    <= 1'b1;
              r_timedOut <= 1'b1;
              r_inst     <= '0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Testbench for ysyx_22040895_ifu.
// Directed fetches drive the bus by hand; expected instructions are queued at issue.
// A negedge monitor pops the queue on every instruction handshake.
module tb_ysyx_22040895_ifu;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
    logic        chkInst;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i_ifu = 1'b0;
  logic [63:0] pc_i_ifu = '0;
  logic        flush_i_ifu = 1'b0;
  logic        ar_valid_o;
  logic        ar_ready_i = 1'b0;
  logic [63:0] ar_addr_o;
  logic        r_valid_i = 1'b0;
  logic        r_ready_o;
  logic [63:0] r_data_i = '0;
  logic [1:0]  r_resp_i = '0;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic        fault_o;

  int  total = 0;
  int  bad   = 0;
  expT sb[$];

  ysyx_22040895_ifu #(.ADDR_W(64), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .ce_i_ifu(ce_i_ifu), .pc_i_ifu(pc_i_ifu), .flush_i_ifu(flush_i_ifu),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
  endtask

  // Monitor: every consumed instruction must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && inst_valid_o && inst_ready_i && !flush_i_ifu) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_inst: got pc %h with empty queue", inst_pc_o);
      end else begin
        expT e;
        e = sb.pop_front();
        checkOutput("inst_pc", inst_pc_o, e.pc);
        checkOutput("fault", {63'd0, fault_o}, {63'd0, e.fault});
        if (e.chkInst) checkOutput("inst", {32'd0, inst_o}, {32'd0, e.inst});
      end
    end
  end

  // A miss: request, optional ar and decode backpressure, one read beat.
  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] data, input logic [1:0] resp,
                               input int arDelay, input int rDelay, input int instDelay,
                               input logic [31:0] expInst, input logic expFault, input logic chkInst);
    logic [63:0] expAddr;
    expAddr = {pc[63:3], 3'b000};
    ce_i_ifu = 1'b1;
    pc_i_ifu = pc;
    step();
    ce_i_ifu = 1'b0;
    checkOutput("ar_valid", {63'd0, ar_valid_o}, 64'd1);
    checkOutput("ar_addr", ar_addr_o, expAddr);
    sb.push_back('{expInst, pc, expFault, chkInst});
    repeat (arDelay) begin
      step();
      checkOutput("ar_valid_hold", {63'd0, ar_valid_o}, 64'd1);
      checkOutput("ar_addr_hold", ar_addr_o, expAddr);
    end
    ar_ready_i = 1'b1;
    step();
    ar_ready_i = 1'b0;
    checkOutput("r_ready", {63'd0, r_ready_o}, 64'd1);
    repeat (rDelay) step();
    r_valid_i = 1'b1;
    r_data_i  = data;
    r_resp_i  = resp;
    step();
    r_valid_i = 1'b0;
    r_resp_i  = 2'b00;
    checkOutput("inst_valid", {63'd0, inst_valid_o}, 64'd1);
    repeat (instDelay) begin
      step();
      checkOutput("inst_valid_hold", {63'd0, inst_valid_o}, 64'd1);
      checkOutput("inst_hold", {32'd0, inst_o}, {32'd0, expInst});
    end
    consume();
  endtask

  // A buffer hit: no bus request, instruction one cycle after accept.
  task automatic applyHit(input logic [63:0] pc, input logic [31:0] expInst);
    ce_i_ifu = 1'b1;
    pc_i_ifu = pc;
    step();
    ce_i_ifu = 1'b0;
    checkOutput("hit_no_ar", {63'd0, ar_valid_o}, 64'd0);
    checkOutput("hit_inst_valid", {63'd0, inst_valid_o}, 64'd1);
    sb.push_back('{expInst, pc, 1'b0, 1'b1});
    consume();
  endtask

  initial begin
    int waited;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ar_valid", {63'd0, ar_valid_o}, 64'd0);
    checkOutput("rst_r_ready", {63'd0, r_ready_o}, 64'd0);
    checkOutput("rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
    checkOutput("rst_fault", {63'd0, fault_o}, 64'd0);
    checkOutput("rst_inst", {32'd0, inst_o}, 64'd0);
    checkOutput("rst_ar_addr", ar_addr_o, 64'd0);
    rst = 1'b1;
    step();

    // Miss then sequential hit
    applyStimulus(64'h8000_0000, 64'h0000_0013_0000_0093, 2'b00, 0, 0, 0, 32'h0000_0093, 1'b0, 1'b1);
    applyHit(64'h8000_0004, 32'h0000_0013);

    // Backpressure on both sides
    applyStimulus(64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 3, 2, 2, 32'hCAFE_F00D, 1'b0, 1'b1);

    // Flush in WAIT: stale beat drained, buffer untouched
    ce_i_ifu = 1'b1;
    pc_i_ifu = 64'h8000_0010;
    step();
    ce_i_ifu = 1'b0;
    ar_ready_i = 1'b1;
    step();
    ar_ready_i = 1'b0;
    flush_i_ifu = 1'b1;
    step();
    flush_i_ifu = 1'b0;
    checkOutput("drain_r_ready", {63'd0, r_ready_o}, 64'd1);
    checkOutput("drain_no_inst", {63'd0, inst_valid_o}, 64'd0);
    step();
    checkOutput("drain_r_ready2", {63'd0, r_ready_o}, 64'd1);
    r_valid_i = 1'b1;
    r_data_i  = 64'h1111_1111_2222_2222;
    step();
    r_valid_i = 1'b0;
    checkOutput("drain_done_r_ready", {63'd0, r_ready_o}, 64'd0);
    checkOutput("drain_done_no_inst", {63'd0, inst_valid_o}, 64'd0);
    applyHit(64'h8000_000C, 32'hDEAD_BEEF);
    applyStimulus(64'h8000_0100, 64'hAAAA_BBBB_1234_5678, 2'b00, 0, 1, 0, 32'h1234_5678, 1'b0, 1'b1);

    // Flush in REQ without ar_ready drops the request
    ce_i_ifu = 1'b1;
    pc_i_ifu = 64'h8000_0200;
    step();
    ce_i_ifu = 1'b0;
    checkOutput("req_ar_valid", {63'd0, ar_valid_o}, 64'd1);
    flush_i_ifu = 1'b1;
    step();
    flush_i_ifu = 1'b0;
    checkOutput("req_flush_ar_valid", {63'd0, ar_valid_o}, 64'd0);
    checkOutput("req_flush_r_ready", {63'd0, r_ready_o}, 64'd0);

    // Flush in OUT overrides inst_ready
    ce_i_ifu = 1'b1;
    pc_i_ifu = 64'h8000_0104;
    step();
    ce_i_ifu = 1'b0;
    checkOutput("out_inst_valid", {63'd0, inst_valid_o}, 64'd1);
    checkOutput("out_inst", {32'd0, inst_o}, {32'd0, 32'hAAAA_BBBB});
    flush_i_ifu  = 1'b1;
    inst_ready_i = 1'b1;
    step();
    flush_i_ifu  = 1'b0;
    inst_ready_i = 1'b0;
    checkOutput("out_flush_inst_valid", {63'd0, inst_valid_o}, 64'd0);
    checkOutput("out_flush_ar_valid", {63'd0, ar_valid_o}, 64'd0);

    // Error response, then refetch must go to the bus again
    applyStimulus(64'h8000_0300, 64'h1234_5678_9ABC_DEF0, 2'b10, 0, 0, 0, 32'h0, 1'b1, 1'b0);
    applyStimulus(64'h8000_0300, 64'h00A0_0093_0050_0513, 2'b00, 0, 0, 0, 32'h0050_0513, 1'b0, 1'b1);

    // Timeout
    ce_i_ifu = 1'b1;
    pc_i_ifu = 64'h8000_0400;
    step();
    ce_i_ifu = 1'b0;
    ar_ready_i = 1'b1;
    step();
    ar_ready_i = 1'b0;
    waited = 0;
    while (!inst_valid_o && waited < 300) begin
      step();
      waited++;
    end
    checkOutput("timeout_cycles", 64'(waited), 64'd255);
    checkOutput("timeout_fault", {63'd0, fault_o}, 64'd1);
    sb.push_back('{32'h0, 64'h8000_0400, 1'b1, 1'b1});
    consume();
    checkOutput("timeout_drain_r_ready", {63'd0, r_ready_o}, 64'd1);
    checkOutput("timeout_drain_no_inst", {63'd0, inst_valid_o}, 64'd0);
    r_valid_i = 1'b1;
    r_data_i  = 64'h5555_5555_6666_6666;
    step();
    r_valid_i = 1'b0;
    checkOutput("timeout_late_done", {63'd0, r_ready_o}, 64'd0);

    // Asynchronous reset mid-WAIT
    ce_i_ifu = 1'b1;
    pc_i_ifu = 64'h8000_0500;
    step();
    ce_i_ifu = 1'b0;
    ar_ready_i = 1'b1;
    step();
    ar_ready_i = 1'b0;
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_ar_valid", {63'd0, ar_valid_o}, 64'd0);
    checkOutput("arst_r_ready", {63'd0, r_ready_o}, 64'd0);
    checkOutput("arst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
    checkOutput("arst_fault", {63'd0, fault_o}, 64'd0);
    checkOutput("arst_inst", {32'd0, inst_o}, 64'd0);
    checkOutput("arst_inst_pc", inst_pc_o, 64'd0);
    checkOutput("arst_ar_addr", ar_addr_o, 64'd0);
    step();
    rst = 1'b1;
    step();

    // Buffer was invalidated by reset: the old 0x80000300 line now misses
    applyStimulus(64'h8000_0304, 64'h00A0_0093_0050_0513, 2'b00, 0, 0, 0, 32'h00A0_0093, 1'b0, 1'b1);

    repeat (2) step();
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
